pe2ddr_axi_wr: RTL

Write-side DDR port for the PE result path. It takes the two decoupled streams produced by the PE write-back stage and emits AXI4 write bursts to the memory controller: a burst-command stream (`ddr*_addr`/`ddr*_size`) and a data stream (`ddr*_data`). One instance is placed per DDR channel (ddr1, ddr2). It owns burst framing (`wlast`), outstanding-transaction limiting and write-response checking.

---
 rtl/pe2ddr_axi_wr.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pe2ddr_axi_wr.sv
// pe2ddr_axi_wr: AXI4 write port for the PE result path.
// Frames W bursts from a length FIFO and bounds outstanding AW bursts.
module pe2ddr_axi_wr #(
   parameter int DDR_ADDR_W = 32,
   parameter int DDR_W      = 512,
   parameter int BURST_W    = 8,
   parameter int MAX_OUT    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DDR_ADDR_W-1:0] ddr_addr,
   input  logic [BURST_W-1:0]    ddr_size,
   input  logic                  ddr_addr_valid,
   output logic                  ddr_addr_ready,
   input  logic [DDR_W-1:0]      ddr_data,
   input  logic                  ddr_valid,
   output logic                  ddr_ready,
   output logic [DDR_ADDR_W-1:0] m_awaddr,
   output logic [7:0]            m_awlen,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [DDR_W-1:0]      m_wdata,
   output logic [DDR_W/8-1:0]    m_wstrb,
   output logic                  m_wlast,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   input  logic                  err_clr,
   output logic                  err_size,
   output logic                  err_resp,
   output logic                  idle
);
   localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW = QW + 1;
   localparam logic [CW-1:0]      OUT_LIM = CW'(MAX_OUT);
   localparam logic [CW-1:0]      C1 = CW'(1);
   localparam logic [QW-1:0]      P1 = QW'(1);
   localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

   typedef enum logic {W_IDLE, W_BURST} w_state_t;

   w_state_t           state, state_nx;
   logic [BURST_W-1:0] beat_cnt, beat_nx;
   logic [BURST_W-1:0] lenq [2**QW];
   logic [QW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      q_cnt, out_cnt;
   logic               lenq_empty, lenq_full;
   logic               acc, push, pop, w_hs, in_burst;

   assign lenq_empty = (q_cnt == '0);
   assign lenq_full  = (q_cnt == OUT_LIM);

   assign ddr_addr_ready = (!m_awvalid | m_awready) & !lenq_full
                         & (out_cnt < OUT_LIM);
   assign acc  = ddr_addr_valid & ddr_addr_ready;
   assign push = acc & (ddr_size != '0);

   assign in_burst  = (state == W_BURST);
   assign m_wdata   = ddr_data;
   assign m_wstrb   = '1;
   assign m_wvalid  = ddr_valid & in_burst;
   assign ddr_ready = m_wready & in_burst;
   assign w_hs      = m_wvalid & m_wready;
   assign m_wlast   = in_burst & (beat_cnt == ONE);
   assign m_bready  = 1'b1;

   assign idle = !m_awvalid & lenq_empty & !in_burst & (out_cnt == '0);

   // AW slice: a new command may overwrite only once the old one drained
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_awvalid <= 1'b0;
         m_awaddr  <= '0;
         m_awlen   <= '0;
      end else if (push) begin
         m_awvalid <= 1'b1;
         m_awaddr  <= ddr_addr;
         m_awlen   <= 8'(ddr_size - ONE);
      end else if (m_awready) begin
         m_awvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) lenq[wr_ptr] <= ddr_size;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         q_cnt  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + P1;
         if (pop)  rd_ptr <= rd_ptr + P1;
         if (push & !pop)      q_cnt <= q_cnt + C1;
         else if (pop & !push) q_cnt <= q_cnt - C1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_cnt <= '0;
      end else if (push & !m_bvalid) begin
         out_cnt <= out_cnt + C1;
      end else if (m_bvalid & !push) begin
         out_cnt <= out_cnt - C1;
      end
   end

   // a fresh error outranks a clear in the same cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_size <= 1'b0;
         err_resp <= 1'b0;
      end else begin
         err_size <= (acc & (ddr_size == '0)) | (err_size & !err_clr);
         err_resp <= (m_bvalid & (m_bresp != 2'b00)) | (err_resp & !err_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= W_IDLE;
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         beat_cnt <= beat_nx;
      end
   end

   always_comb begin
      state_nx = state;
      beat_nx  = beat_cnt;
      pop      = 1'b0;
      unique case (state)
         W_IDLE: begin
            if (!lenq_empty) begin
               pop      = 1'b1;
               beat_nx  = lenq[rd_ptr];
               state_nx = W_BURST;
            end
         end
         W_BURST: begin
            if (w_hs) begin
               if (beat_cnt == ONE && !lenq_empty) begin
                  pop     = 1'b1;
                  beat_nx = lenq[rd_ptr];
               end else begin
                  beat_nx = beat_cnt - ONE;
                  if (beat_cnt == ONE) state_nx = W_IDLE;
               end
            end
         end
         default: state_nx = W_IDLE;
      endcase
   end

endmodule
